// File: rtl/iob_regfile_1wnr_if.sv
// Bus bundle for the 1-write / N-read register file: write port, clear, and
// per-read-port address/enable/data/valid vectors.
interface iob_regfile_1wnr_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int N_RD   = 2
);
  logic                     clear_i;
  logic                     w_en_i;
  logic [ADDR_W-1:0]        w_addr_i;
  logic [DATA_W/8-1:0]      w_strb_i;
  logic [DATA_W-1:0]        w_data_i;
  logic [N_RD-1:0]          r_en_i;
  logic [N_RD*ADDR_W-1:0]   r_addr_i;
  logic [N_RD*DATA_W-1:0]   r_data_o;
  logic [N_RD-1:0]          r_valid_o;

  modport master (
    output clear_i, w_en_i, w_addr_i, w_strb_i, w_data_i, r_en_i, r_addr_i,
    input  r_data_o, r_valid_o
  );

  modport slave (
    input  clear_i, w_en_i, w_addr_i, w_strb_i, w_data_i, r_en_i, r_addr_i,
    output r_data_o, r_valid_o
  );
endinterface

// File: rtl/iob_regfile_1wnr.sv
// Register file with one byte-strobed write port, N registered read ports,
// per-entry valid flags, synchronous clear and optional write-first forwarding.
module iob_regfile_1wnr #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int N_RD   = 2,
  parameter int BYPASS = 0
) (
  input logic                clk_i,
  input logic                cke_i,
  input logic                arst_i,
  iob_regfile_1wnr_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] merged;
  logic              do_write;
  logic [DATA_W-1:0] rd_data [N_RD];
  logic [N_RD-1:0]   rd_valid;

  function automatic logic [ADDR_W-1:0] rd_addr(input int k);
    return bus.r_addr_i[k*ADDR_W +: ADDR_W];
  endfunction

  // An all-zero strobe is a no-op, so it must not mark the entry valid.
  assign do_write = bus.w_en_i && (|bus.w_strb_i) && !bus.clear_i;

  // Post-write image of the target entry; used both for storage and forwarding.
  always_comb begin
    merged = mem[bus.w_addr_i];
    for (int b = 0; b < NB; b++) begin
      if (bus.w_strb_i[b]) begin
        merged[8*b +: 8] = bus.w_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (cke_i) begin
      if (bus.clear_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
        valid <= '0;
      end else if (do_write) begin
        mem[bus.w_addr_i]   <= merged;
        valid[bus.w_addr_i] <= 1'b1;
      end
    end
  end

  // Read ports sample pre-edge storage unless forwarding is enabled.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int k = 0; k < N_RD; k++) begin
        rd_data[k] <= '0;
      end
      rd_valid <= '0;
    end else if (cke_i) begin
      for (int k = 0; k < N_RD; k++) begin
        if (bus.r_en_i[k]) begin
          if (BYPASS != 0 && bus.clear_i) begin
            rd_data[k]  <= '0;
            rd_valid[k] <= 1'b0;
          end else if (BYPASS != 0 && do_write && rd_addr(k) == bus.w_addr_i) begin
            rd_data[k]  <= merged;
            rd_valid[k] <= 1'b1;
          end else begin
            rd_data[k]  <= mem[rd_addr(k)];
            rd_valid[k] <= valid[rd_addr(k)];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_out
    assign bus.r_data_o[k*DATA_W +: DATA_W] = rd_data[k];
  end
  assign bus.r_valid_o = rd_valid;

endmodule

// File: tb/tb_iob_regfile_1wnr.sv
// Checks the register file in both read modes side by side against an
// array-based reference model, with directed scenarios and random traffic.
module tb_iob_regfile_1wnr;
  logic clk = 1'b0;
  logic cke;
  logic arst;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem_m [8];
  logic        val_m [8];
  logic [31:0] exp_d [2][2];
  logic        exp_v [2][2];

  iob_regfile_1wnr_if #(.ADDR_W(3), .DATA_W(32), .N_RD(2)) if0 ();
  iob_regfile_1wnr_if #(.ADDR_W(3), .DATA_W(32), .N_RD(2)) if1 ();

  assign if1.clear_i  = if0.clear_i;
  assign if1.w_en_i   = if0.w_en_i;
  assign if1.w_addr_i = if0.w_addr_i;
  assign if1.w_strb_i = if0.w_strb_i;
  assign if1.w_data_i = if0.w_data_i;
  assign if1.r_en_i   = if0.r_en_i;
  assign if1.r_addr_i = if0.r_addr_i;

  iob_regfile_1wnr #(.ADDR_W(3), .DATA_W(32), .N_RD(2), .BYPASS(0)) dut0 (
    .clk_i (clk), .cke_i (cke), .arst_i (arst), .bus (if0)
  );
  iob_regfile_1wnr #(.ADDR_W(3), .DATA_W(32), .N_RD(2), .BYPASS(1)) dut1 (
    .clk_i (clk), .cke_i (cke), .arst_i (arst), .bus (if1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs_d(input int d, input int k);
    return (d == 0) ? if0.r_data_o[k*32 +: 32] : if1.r_data_o[k*32 +: 32];
  endfunction

  function automatic logic obs_v(input int d, input int k);
    return (d == 0) ? if0.r_valid_o[k] : if1.r_valid_o[k];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_output();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        check_val($sformatf("bypass%0d_port%0d_data", d, k), obs_d(d, k), exp_d[d][k]);
        check_val($sformatf("bypass%0d_port%0d_valid", d, k), {31'b0, obs_v(d, k)}, {31'b0, exp_v[d][k]});
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = '0;
      val_m[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        exp_d[d][k] = '0;
        exp_v[d][k] = 1'b0;
      end
    end
  endtask

  task automatic apply_stimulus(input logic c, input logic clr, input logic wen,
                                input logic [2:0] wa, input logic [3:0] strb,
                                input logic [31:0] wd, input logic [1:0] ren,
                                input logic [2:0] ra0, input logic [2:0] ra1);
    cke          = c;
    if0.clear_i  = clr;
    if0.w_en_i   = wen;
    if0.w_addr_i = wa;
    if0.w_strb_i = strb;
    if0.w_data_i = wd;
    if0.r_en_i   = ren;
    if0.r_addr_i = {ra1, ra0};
  endtask

  // Predict the effect of the coming edge from the rules, then clock and compare.
  task automatic clock_step();
    logic [31:0] new_word;
    logic        wr;
    logic [2:0]  a;
    if (cke) begin
      new_word = mem_m[if0.w_addr_i];
      for (int b = 0; b < 4; b++) begin
        if (if0.w_strb_i[b]) new_word[8*b +: 8] = if0.w_data_i[8*b +: 8];
      end
      wr = if0.w_en_i && (if0.w_strb_i != 4'h0) && !if0.clear_i;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 2; k++) begin
          if (if0.r_en_i[k]) begin
            a = if0.r_addr_i[k*3 +: 3];
            if (d == 1 && if0.clear_i) begin
              exp_d[d][k] = '0;
              exp_v[d][k] = 1'b0;
            end else if (d == 1 && wr && a == if0.w_addr_i) begin
              exp_d[d][k] = new_word;
              exp_v[d][k] = 1'b1;
            end else begin
              exp_d[d][k] = mem_m[a];
              exp_v[d][k] = val_m[a];
            end
          end
        end
      end
      if (if0.clear_i) begin
        for (int i = 0; i < 8; i++) begin
          mem_m[i] = '0;
          val_m[i] = 1'b0;
        end
      end else if (wr) begin
        mem_m[if0.w_addr_i] = new_word;
        val_m[if0.w_addr_i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    model_reset();
    arst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 2'b00, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check_output();
    arst = 1'b0;

    // Write then read, with the second port looking at an unwritten entry.
    apply_stimulus(1, 0, 1, 3'd5, 4'hF, 32'hDEADBEEF, 2'b00, 3'd0, 3'd0);
    clock_step();
    apply_stimulus(1, 0, 0, 3'd0, 4'h0, 32'h0, 2'b11, 3'd5, 3'd4);
    clock_step();
    check_val("wr_rd_data", obs_d(0, 0), 32'hDEADBEEF);
    check_val("wr_rd_valid", {31'b0, obs_v(0, 0)}, 32'd1);
    check_val("unwritten_data", obs_d(0, 1), 32'h0);
    check_val("unwritten_valid", {31'b0, obs_v(0, 1)}, 32'd0);

    // Byte strobes merge into the existing word.
    apply_stimulus(1, 0, 1, 3'd2, 4'hF, 32'h11223344, 2'b00, 3'd0, 3'd0);
    clock_step();
    apply_stimulus(1, 0, 1, 3'd2, 4'h5, 32'hAABBCCDD, 2'b00, 3'd0, 3'd0);
    clock_step();
    apply_stimulus(1, 0, 1, 3'd6, 4'h0, 32'hFFFFFFFF, 2'b01, 3'd2, 3'd0);
    clock_step();
    check_val("strobe_merge", obs_d(0, 0), 32'h11BB33DD);

    // Same-cycle write and read of one address in both modes.
    apply_stimulus(1, 0, 1, 3'd3, 4'hF, 32'h1, 2'b00, 3'd0, 3'd0);
    clock_step();
    apply_stimulus(1, 0, 1, 3'd3, 4'hF, 32'h2, 2'b10, 3'd0, 3'd3);
    clock_step();
    check_val("rbw_data", obs_d(0, 1), 32'h1);
    check_val("fwd_data", obs_d(1, 1), 32'h2);
    apply_stimulus(1, 0, 0, 3'd0, 4'h0, 32'h0, 2'b10, 3'd0, 3'd3);
    clock_step();
    check_val("after_rbw", obs_d(0, 1), 32'h2);
    check_val("after_fwd", obs_d(1, 1), 32'h2);

    // Clear wins over a simultaneous write.
    apply_stimulus(1, 1, 1, 3'd1, 4'hF, 32'h55, 2'b11, 3'd1, 3'd5);
    clock_step();
    check_val("clear_same_cycle_fwd", obs_d(1, 1), 32'h0);
    apply_stimulus(1, 0, 0, 3'd0, 4'h0, 32'h0, 2'b11, 3'd1, 3'd5);
    clock_step();
    check_val("clear_addr1", obs_d(0, 0), 32'h0);
    check_val("clear_addr1_valid", {31'b0, obs_v(0, 0)}, 32'd0);

    // Clock enable low freezes everything; read enable low holds a port.
    apply_stimulus(1, 0, 1, 3'd6, 4'hF, 32'hCAFEF00D, 2'b00, 3'd0, 3'd0);
    clock_step();
    apply_stimulus(1, 0, 0, 3'd0, 4'h0, 32'h0, 2'b11, 3'd6, 3'd6);
    clock_step();
    apply_stimulus(0, 0, 1, 3'd6, 4'hF, 32'h12345678, 2'b11, 3'd0, 3'd0);
    clock_step();
    check_val("cke_hold", obs_d(0, 0), 32'hCAFEF00D);
    apply_stimulus(1, 0, 1, 3'd7, 4'hF, 32'h77777777, 2'b00, 3'd6, 3'd6);
    clock_step();
    apply_stimulus(1, 0, 0, 3'd0, 4'h0, 32'h0, 2'b11, 3'd6, 3'd7);
    clock_step();
    check_val("cke_no_write", obs_d(0, 0), 32'hCAFEF00D);

    // Reset pulse between edges after several writes.
    apply_stimulus(1, 0, 1, 3'd0, 4'hF, 32'h0BADC0DE, 2'b11, 3'd6, 3'd7);
    clock_step();
    apply_stimulus(1, 0, 1, 3'd4, 4'h3, 32'h00004444, 2'b01, 3'd0, 3'd0);
    clock_step();
    #2;
    arst = 1'b1;
    #1;
    model_reset();
    check_output();
    #1;
    arst = 1'b0;
    for (int a = 0; a < 8; a += 2) begin
      apply_stimulus(1, 0, 0, 3'd0, 4'h0, 32'h0, 2'b11, 3'(a), 3'(a + 1));
      clock_step();
    end

    // Random traffic, biased so reads often hit the write address.
    for (int n = 0; n < 300; n++) begin
      logic [2:0] wa;
      wa = 3'($urandom_range(0, 7));
      apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                     1'($urandom), wa, 4'($urandom), $urandom, 2'($urandom),
                     ($urandom_range(0, 2) == 0) ? wa : 3'($urandom),
                     ($urandom_range(0, 2) == 0) ? wa : 3'($urandom));
      clock_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
